// File: rtl/bta_cla_32.sv
// Pipelined multi-operand adder: N unsigned m-bit operands plus a carry-in, summed by a
// balanced binary tree of carry-lookahead adders with one register stage per tree level.

module bta_cla_add #(
    parameter int W = 16
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W:0]   sum_o
);
    // Full 4-bit groups only; a short top group (W not a multiple of 4) hangs off gc[NG].
    localparam int NG = W / 4;

    logic [W-1:0]  g, p;
    logic [W:0]    c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;

    always_comb begin
        logic acc, prod;
        g    = a_i & b_i;
        p    = a_i ^ b_i;
        gg   = '0;
        gp   = '0;
        gc   = '0;
        c    = '0;
        acc  = 1'b0;
        prod = 1'b1;

        for (int k = 0; k < NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int b = 3; b >= 0; b--) begin
                acc  = acc | (prod & g[4*k+b]);
                prod = prod & p[4*k+b];
            end
            gg[k] = acc;
            gp[k] = prod;
        end

        // Group carries are fully expanded sum-of-products, not a group ripple.
        gc[0] = cin_i;
        for (int k = 0; k < NG; k++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int j = k; j >= 0; j--) begin
                acc  = acc | (prod & gg[j]);
                prod = prod & gp[j];
            end
            gc[k+1] = acc | (prod & cin_i);
        end

        for (int i = 0; i <= W; i++) begin
            acc  = 1'b0;
            prod = 1'b1;
            for (int b = (i % 4) - 1; b >= 0; b--) begin
                acc  = acc | (prod & g[i-(i%4)+b]);
                prod = prod & p[i-(i%4)+b];
            end
            c[i] = acc | (prod & gc[i/4]);
        end
    end

    assign sum_o = {c[W], p ^ c[W-1:0]};
endmodule

module bta_cla_32 #(
    parameter int N = 32,
    parameter int m = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [m*(N/8)-1:0]        A,
    input  logic [m*(N/8)-1:0]        B,
    input  logic [m*(N/8)-1:0]        C,
    input  logic [m*(N/8)-1:0]        D,
    input  logic [m*(N/8)-1:0]        E,
    input  logic [m*(N/8)-1:0]        F,
    input  logic [m*(N/8)-1:0]        G,
    input  logic [m*(N/8)-1:0]        H,
    input  logic                      C0,
    output logic [m+$clog2(N)-1:0]    sum,
    output logic                      carry
);
    localparam int LG = $clog2(N);

    // Operand k = (N/8)*port + slice; A occupies the low end.
    logic [N-1:0][m-1:0] ops;
    assign ops = {H, G, F, E, D, C, B, A};

    for (genvar L = 1; L <= LG; L++) begin : g_lvl
        localparam int NA = N >> L;
        localparam int AW = m + L - 1;

        logic [2*NA-1:0][AW-1:0] in_w;
        logic [NA-1:0][AW:0]     res_d;
        logic [NA-1:0][AW:0]     res_q;

        if (L == 1) begin : g_src
            assign in_w = ops;
        end else begin : g_src
            assign in_w = g_lvl[L-1].res_q;
        end

        for (genvar i = 0; i < NA; i++) begin : g_add
            bta_cla_add #(.W(AW)) u_add (
                .a_i   (in_w[2*i]),
                .b_i   (in_w[2*i+1]),
                .cin_i ((L == 1 && i == 0) ? C0 : 1'b0),
                .sum_o (res_d[i])
            );
        end

        always_ff @(posedge clk) begin
            if (rst) res_q <= '0;
            else     res_q <= res_d;
        end
    end

    assign sum = g_lvl[LG].res_q[0];
    // N*(2^m-1)+1 < 2^(m+log2 N) for any N > 1, so bit m+log2(N) of the total is always 0.
    assign carry = 1'b0;
endmodule

// File: tb/tb_bta_cla_32.sv
// Scoreboard bench for bta_cla_32: expected totals queued at drive time, popped at due cycle.

module tb_bta_cla_32;
    localparam int N  = 32;
    localparam int M  = 16;
    localparam int PW = M * (N / 8);
    localparam int SW = M + $clog2(N);

    logic          clk, rst, C0, carry;
    logic [PW-1:0] A, B, C, D, E, F, G, H;
    logic [SW-1:0] sum;

    typedef struct { logic [7:0][63:0] p; logic c0; } vec_t;
    typedef struct { logic [SW:0] val; int due; string tag; } exp_t;

    exp_t sbq[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;

    bta_cla_32 #(.N(N), .m(M)) dut (
        .clk(clk), .rst(rst),
        .A(A), .B(B), .C(C), .D(D), .E(E), .F(F), .G(G), .H(H),
        .C0(C0), .sum(sum), .carry(carry)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [SW:0] model(input vec_t v);
        logic [SW:0] t;
        t = (SW+1)'(v.c0);
        for (int p = 0; p < 8; p++)
            for (int j = 0; j < 4; j++)
                t += (SW+1)'(v.p[p][16*j +: 16]);
        return t;
    endfunction

    function automatic vec_t zero_vec();
        vec_t v;
        v.p  = '0;
        v.c0 = 1'b0;
        return v;
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        for (int p = 0; p < 8; p++) begin
            v.p[p] = {$urandom, $urandom};
            if ($urandom_range(0, 3) == 0) v.p[p] = '1;
        end
        v.c0 = 1'($urandom_range(0, 1));
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        {H, G, F, E, D, C, B, A} = v.p;
        C0 = v.c0;
    endtask

    // Inputs driven now are sampled at the next edge and surface four edges after that.
    task automatic send(input vec_t v, input logic [SW:0] val, input string tag);
        exp_t e;
        drive(v);
        e.val = val;
        e.due = cyc + 5;
        e.tag = tag;
        sbq.push_back(e);
    endtask

    task automatic test_reset();
        vec_t v;
        v.p  = '1;
        v.c0 = 1'b1;
        rst  = 1'b1;
        drive(v);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({carry, sum} !== '0) begin
                errors++;
                $display("FAIL reset_%0d: {carry,sum}=%h expected 0", i, {carry, sum});
            end
        end
    endtask

    task automatic test_zero();
        drive(zero_vec());
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if ({carry, sum} !== '0) begin
                errors++;
                $display("FAIL zero_%0d: {carry,sum}=%h expected 0", i, {carry, sum});
            end
        end
    endtask

    task automatic test_vector(input vec_t v, input logic [SW:0] val, input string tag);
        exp_t e;
        send(v, val, tag);
        for (int i = 0; i < 10 && sbq.size() != 0; i++) begin
            tick();
            drive(zero_vec());
            if (sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checks++;
                if ({carry, sum} !== e.val) begin
                    errors++;
                    $display("FAIL %s: {carry,sum}=%h expected %h", e.tag, {carry, sum}, e.val);
                end
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout: %0d results outstanding, expected 0", tag, sbq.size());
            sbq.delete();
        end
    endtask

    task automatic test_directed();
        vec_t v;
        v.p[0] = 64'h546239F8EAB23C98;
        v.p[1] = 64'h1234567890ABCDEF;
        v.p[2] = 64'h9876543210FEDCBA;
        v.p[3] = 64'hFFFFF66666555555;
        v.p[4] = 64'h0001000100010001;
        v.p[5] = 64'h0010001000100010;
        v.p[6] = 64'h0011001100110011;
        v.p[7] = 64'h0100010001000100;
        v.c0   = 1'b0;
        test_vector(v, 22'h080DE1, "directed");
    endtask

    task automatic test_max();
        vec_t v;
        v.p  = '1;
        v.c0 = 1'b1;
        test_vector(v, 22'h1FFFE1, "max");
    endtask

    task automatic test_slices();
        vec_t v;
        exp_t e;
        v = zero_vec();
        v.p[7][63:48] = 16'hFFFF;
        v.c0 = 1'b1;
        test_vector(v, 22'h010000, "op31_c0");
        // Walk a single nonzero operand through every slot, back to back.
        for (int k = 0; k < 32; k++) begin
            v = zero_vec();
            v.p[k/4][16*(k%4) +: 16] = 16'(65535 - 977 * k);
            v.c0 = 1'(k % 2);
            send(v, model(v), $sformatf("slice_%0d", k));
            tick();
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checks++;
                if ({carry, sum} !== e.val) begin
                    errors++;
                    $display("FAIL %s: {carry,sum}=%h expected %h", e.tag, {carry, sum}, e.val);
                end
            end
        end
        test_vector(zero_vec(), '0, "slice_drain");
    endtask

    task automatic test_back_to_back();
        vec_t v;
        exp_t e;
        for (int k = 0; k < 24; k++) begin
            v = rand_vec();
            send(v, model(v), $sformatf("b2b_%0d", k));
            tick();
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checks++;
                if ({carry, sum} !== e.val) begin
                    errors++;
                    $display("FAIL %s: {carry,sum}=%h expected %h", e.tag, {carry, sum}, e.val);
                end
            end
        end
        test_vector(zero_vec(), '0, "b2b_drain");
    endtask

    task automatic test_reset_midstream();
        vec_t v;
        exp_t e;
        for (int k = 0; k < 6; k++) begin
            v = rand_vec();
            send(v, model(v), $sformatf("pre_rst_%0d", k));
            tick();
            if (sbq.size() != 0 && sbq[0].due == cyc) begin
                e = sbq.pop_front();
                checks++;
                if ({carry, sum} !== e.val) begin
                    errors++;
                    $display("FAIL %s: {carry,sum}=%h expected %h", e.tag, {carry, sum}, e.val);
                end
            end
        end
        rst = 1'b1;
        drive(rand_vec());
        tick();
        sbq.delete();
        checks++;
        if ({carry, sum} !== '0) begin
            errors++;
            $display("FAIL rst_full: {carry,sum}=%h expected 0", {carry, sum});
        end
        rst = 1'b0;
        drive(zero_vec());
        for (int i = 0; i < 7; i++) begin
            tick();
            checks++;
            if ({carry, sum} !== '0) begin
                errors++;
                $display("FAIL stale_%0d: {carry,sum}=%h expected 0", i, {carry, sum});
            end
        end
        v = rand_vec();
        test_vector(v, model(v), "post_rst");
    endtask

    initial begin
        test_reset();
        test_zero();
        test_directed();
        test_max();
        test_slices();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, expected completion");
        $fatal(1, "watchdog");
    end
endmodule
